// File: rtl/tdc_frame_collector.sv
// Per-frame reducer for the tdc_top hit stream: picks the best hit, counts hits,
// flags range drops and count overflow, and hands one result per frame downstream.
module tdc_frame_collector #(
    parameter int DW       = 15,
    parameter int IW       = 4,
    parameter int MAX_HITS = 4,
    parameter int FIDW     = 8
) (
    input  logic            clk,
    input  logic            rst_auto,
    input  logic [DW-1:0]   range_i,
    input  logic [DW-1:0]   s_data,
    input  logic [IW-1:0]   s_int,
    input  logic [1:0]      s_num,
    input  logic            s_last,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [DW-1:0]   m_depth,
    output logic [IW-1:0]   m_int,
    output logic [2:0]      m_cnt,
    output logic            m_drop,
    output logic            m_ovf,
    output logic [FIDW-1:0] m_fid,
    output logic            m_valid,
    input  logic            m_ready
);

    localparam logic [2:0] CNT_MAX = 3'(MAX_HITS);

    typedef enum logic {ACC, EMIT} state_t;

    state_t state, state_nxt;

    logic [DW-1:0] best_depth, depth_nxt;
    logic [IW-1:0] best_int, int_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic          drop, drop_nxt;
    logic          ovf, ovf_nxt;

    logic take;
    logic out_hs;
    logic is_hit;
    logic in_range;
    logic better;

    assign take     = s_valid && s_ready;
    assign out_hs   = m_valid && m_ready;
    assign is_hit   = (s_num != 2'd0);
    assign in_range = (s_data <= range_i);
    // The first accepted hit always wins; afterwards higher intensity, then nearer depth.
    assign better   = (cnt == 3'd0) || (s_int > best_int) ||
                      ((s_int == best_int) && (s_data < best_depth));

    always_ff @(posedge clk or negedge rst_auto) begin
        if (!rst_auto) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        case (state)
            ACC: begin
                s_ready = 1'b1;
                if (take && s_last) state_nxt = EMIT;
            end
            EMIT: begin
                m_valid = 1'b1;
                if (m_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    // Accumulator update for the beat being taken this cycle.
    always_comb begin
        depth_nxt = best_depth;
        int_nxt   = best_int;
        cnt_nxt   = cnt;
        drop_nxt  = drop;
        ovf_nxt   = ovf;
        if (take && is_hit) begin
            if (in_range) begin
                if (cnt == CNT_MAX) ovf_nxt = 1'b1;
                else                cnt_nxt = cnt + 3'd1;
                // Best selection continues past saturation.
                if (better) begin
                    depth_nxt = s_data;
                    int_nxt   = s_int;
                end
            end else begin
                drop_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_auto) begin
        if (!rst_auto) begin
            best_depth <= '0;
            best_int   <= '0;
            cnt        <= '0;
            drop       <= 1'b0;
            ovf        <= 1'b0;
        end else if (out_hs) begin
            best_depth <= '0;
            best_int   <= '0;
            cnt        <= '0;
            drop       <= 1'b0;
            ovf        <= 1'b0;
        end else if (take) begin
            best_depth <= depth_nxt;
            best_int   <= int_nxt;
            cnt        <= cnt_nxt;
            drop       <= drop_nxt;
            ovf        <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_auto) begin
        if (!rst_auto) begin
            m_depth <= '0;
            m_int   <= '0;
            m_cnt   <= '0;
            m_drop  <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (take && s_last) begin
            m_depth <= depth_nxt;
            m_int   <= int_nxt;
            m_cnt   <= cnt_nxt;
            m_drop  <= drop_nxt;
            m_ovf   <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_auto) begin
        if (!rst_auto) begin
            m_fid <= '0;
        end else if (out_hs) begin
            m_fid <= m_fid + 1'b1;
        end
    end

endmodule

// File: tb/tb_tdc_frame_collector.sv
// Directed bench for tdc_frame_collector: hand-computed frames, overflow, drops,
// back-pressure and mid-frame reset.
module tb_tdc_frame_collector;

    logic        clk;
    logic        rst_auto;
    logic [14:0] range_i;
    logic [14:0] s_data;
    logic [3:0]  s_int;
    logic [1:0]  s_num;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [14:0] m_depth;
    logic [3:0]  m_int;
    logic [2:0]  m_cnt;
    logic        m_drop;
    logic        m_ovf;
    logic [7:0]  m_fid;
    logic        m_valid;
    logic        m_ready;

    int n_run  = 0;
    int n_fail = 0;

    tdc_frame_collector dut (
        .clk(clk), .rst_auto(rst_auto), .range_i(range_i),
        .s_data(s_data), .s_int(s_int), .s_num(s_num), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_depth(m_depth), .m_int(m_int), .m_cnt(m_cnt), .m_drop(m_drop),
        .m_ovf(m_ovf), .m_fid(m_fid), .m_valid(m_valid), .m_ready(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one beat; returns #1 after the edge that takes it.
    task automatic beat(input int d, input int i, input int n, input bit last);
        int budget = 20;
        while (!s_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk("beat_ready_timeout", {31'd0, s_ready}, 32'd1);
        s_data  = 15'(d);
        s_int   = 4'(i);
        s_num   = 2'(n);
        s_last  = last;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input int d, input int i, input int c,
                                input bit dr, input bit ov, input int fid);
        chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        chk({tag, "_sready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_depth"}, {17'd0, m_depth}, 32'(d));
        chk({tag, "_int"}, {28'd0, m_int}, 32'(i));
        chk({tag, "_cnt"}, {29'd0, m_cnt}, 32'(c));
        chk({tag, "_drop"}, {31'd0, m_drop}, {31'd0, dr});
        chk({tag, "_ovf"}, {31'd0, m_ovf}, {31'd0, ov});
        chk({tag, "_fid"}, {24'd0, m_fid}, 32'(fid));
    endtask

    task automatic handshake(input string tag);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk({tag, "_hs_mvalid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, "_hs_sready"}, {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        rst_auto = 1'b0;
        range_i  = 15'd4092;
        s_data   = 15'd123;
        s_int    = 4'd5;
        s_num    = 2'd1;
        s_last   = 1'b1;
        s_valid  = 1'b1;
        m_ready  = 1'b0;

        // 1: reset with s_valid high
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_auto = 1'b1;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        chk("rst_sready", {31'd0, s_ready}, 32'd1);
        chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("rst_fid", {24'd0, m_fid}, 32'd0);
        chk("rst_cnt", {29'd0, m_cnt}, 32'd0);
        @(posedge clk); #1;
        chk("rst_idle_mvalid", {31'd0, m_valid}, 32'd0);

        // 2: best by intensity, tie broken by smaller depth
        beat(100, 3, 1, 0);
        beat(50, 7, 1, 0);
        chk("f2_not_yet", {31'd0, m_valid}, 32'd0);
        beat(60, 7, 1, 1);
        expect_frame("f2", 50, 7, 3, 0, 0, 0);
        handshake("f2");

        // 3: out-of-range hit dropped
        beat(5000, 9, 1, 0);
        beat(200, 2, 2, 1);
        expect_frame("f3", 200, 2, 1, 1, 0, 1);
        handshake("f3");

        // 4: six hits, saturation; best arrives after saturation
        beat(300, 1, 1, 0);
        beat(250, 5, 1, 0);
        beat(400, 5, 1, 0);
        beat(100, 2, 1, 0);
        beat(260, 5, 1, 0);
        beat(90, 6, 1, 1);
        expect_frame("f4", 90, 6, 4, 0, 1, 2);
        handshake("f4");

        // 5: empty frame held under back-pressure
        beat(77, 3, 0, 1);
        for (int k = 0; k < 5; k++) begin
            chk("f5_hold_valid", {31'd0, m_valid}, 32'd1);
            chk("f5_hold_sready", {31'd0, s_ready}, 32'd0);
            @(posedge clk); #1;
        end
        expect_frame("f5", 0, 0, 0, 0, 0, 3);
        handshake("f5");

        // range boundary: data == range accepted, range+1 dropped
        beat(4093, 8, 1, 0);
        beat(4092, 1, 1, 1);
        expect_frame("fb", 4092, 1, 1, 1, 0, 4);
        handshake("fb");

        // 6: reset mid-frame discards partial result and fid
        beat(20, 5, 1, 0);
        beat(30, 6, 1, 0);
        rst_auto = 1'b0;
        #3;
        chk("f6_rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("f6_rst_fid", {24'd0, m_fid}, 32'd0);
        @(negedge clk);
        rst_auto = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("f6_no_emit", {31'd0, m_valid}, 32'd0);
        beat(40, 2, 1, 1);
        expect_frame("f6", 40, 2, 1, 0, 0, 0);
        handshake("f6");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
